// File: rtl/product_display.sv
// rtl/product_display.sv - captures the multiplier product, converts it to BCD by double-dabble and scans a 4-digit 7-segment display.
module product_display #(
  parameter int W        = 7,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int LZB      = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           done_in,
  input  logic [W-1:0]   product_in,
  output logic           busy,
  output logic [15:0]    bcd_out,
  output logic           bcd_valid,
  output logic [3:0]     an,
  output logic [6:0]     seg,
  output logic           dp
);

  localparam int SW = 16 + W;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [1:0]    DIGIT_LAST = 2'(DIGITS - 1);
  localparam logic [3:0]    SHIFT_LAST = 4'(W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] sreg;
  logic [SW-1:0] sreg_next;
  logic [15:0]   adj;
  logic [3:0]    cnt;
  logic          done_d;
  logic          done_rise;
  logic          pending;
  logic [W-1:0]  pend_val;

  assign done_rise = done_in & ~done_d;

  // Double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    adj = sreg[SW-1:W];
    for (int i = 0; i < 4; i++) begin
      if (sreg[W+4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = sreg[W+4*i +: 4] + 4'd3;
    end
    sreg_next = {adj[14:0], sreg[W-1:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      bcd_out   <= 16'd0;
      bcd_valid <= 1'b0;
      pending   <= 1'b0;
      pend_val  <= '0;
      sreg      <= '0;
      cnt       <= 4'd0;
      done_d    <= 1'b0;
    end else begin
      done_d    <= done_in;
      bcd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (done_rise) begin
            sreg  <= {16'd0, product_in};
            cnt   <= 4'd0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sreg <= sreg_next;
          cnt  <= cnt + 4'd1;
          if (cnt == SHIFT_LAST)
            state <= S_LOAD;
          if (done_rise) begin
            pending  <= 1'b1;
            pend_val <= product_in;
          end
        end
        S_LOAD: begin
          bcd_out   <= sreg[SW-1:W];
          bcd_valid <= 1'b1;
          cnt       <= 4'd0;
          if (pending) begin
            // Oldest capture first; a rise in this same cycle becomes the new pending value.
            sreg    <= {16'd0, pend_val};
            state   <= S_SHIFT;
            pending <= done_rise;
            if (done_rise)
              pend_val <= product_in;
          end else if (done_rise) begin
            sreg  <= {16'd0, product_in};
            state <= S_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [1:0]    cur_digit;
  logic          scan_tick;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_sel;

  always_comb begin
    nib = bcd_out[4*cur_digit +: 4];
    blank = 1'b0;
    if (LZB != 0) begin
      case (cur_digit)
        2'd1:    blank = (bcd_out[15:4] == 12'd0);
        2'd2:    blank = (bcd_out[15:8] == 8'd0);
        2'd3:    blank = (bcd_out[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
    case (nib)
      4'd0:    seg_sel = 7'b1000000;
      4'd1:    seg_sel = 7'b1111001;
      4'd2:    seg_sel = 7'b0100100;
      4'd3:    seg_sel = 7'b0110000;
      4'd4:    seg_sel = 7'b0011001;
      4'd5:    seg_sel = 7'b0010010;
      4'd6:    seg_sel = 7'b0000010;
      4'd7:    seg_sel = 7'b1111000;
      4'd8:    seg_sel = 7'b0000000;
      4'd9:    seg_sel = 7'b0010000;
      default: seg_sel = 7'b1111111;
    endcase
    if (blank)
      seg_sel = 7'b1111111;
  end

  // cur_digit is latched at the wrap so the slot just opened shows digit 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      cur_digit <= 2'd0;
      scan_tick <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      dp        <= 1'b1;
      scan_tick <= 1'b0;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        scan_tick <= 1'b1;
        cur_digit <= digit_idx;
        digit_idx <= (digit_idx == DIGIT_LAST) ? 2'd0 : digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (scan_tick) begin
        an  <= ~(4'b0001 << cur_digit);
        seg <= seg_sel;
      end
    end
  end

endmodule

// File: tb/tb_product_display.sv
// tb/tb_product_display.sv - directed bench for product_display (W=7 with and without blanking, W=13).
module tb_product_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        done7;
  logic [6:0]  prod7;
  logic        done13;
  logic [12:0] prod13;

  logic        busy_a, valid_a, dp_a;
  logic [15:0] bcd_a;
  logic [3:0]  an_a;
  logic [6:0]  seg_a;
  logic        busy_b, valid_b, dp_b;
  logic [15:0] bcd_b;
  logic [3:0]  an_b;
  logic [6:0]  seg_b;
  logic        busy_c, valid_c, dp_c;
  logic [15:0] bcd_c;
  logic [3:0]  an_c;
  logic [6:0]  seg_c;

  int total = 0;
  int bad   = 0;

  product_display #(.W(7), .DIGITS(4), .SCAN_DIV(4), .LZB(1)) dut_a (
    .clk(clk), .rst(rst), .done_in(done7), .product_in(prod7),
    .busy(busy_a), .bcd_out(bcd_a), .bcd_valid(valid_a), .an(an_a), .seg(seg_a), .dp(dp_a));

  product_display #(.W(7), .DIGITS(4), .SCAN_DIV(4), .LZB(0)) dut_b (
    .clk(clk), .rst(rst), .done_in(done7), .product_in(prod7),
    .busy(busy_b), .bcd_out(bcd_b), .bcd_valid(valid_b), .an(an_b), .seg(seg_b), .dp(dp_b));

  product_display #(.W(13), .DIGITS(4), .SCAN_DIV(4), .LZB(1)) dut_c (
    .clk(clk), .rst(rst), .done_in(done13), .product_in(prod13),
    .busy(busy_c), .bcd_out(bcd_c), .bcd_valid(valid_c), .an(an_c), .seg(seg_c), .dp(dp_c));

  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Watches one rotation-and-a-half of the scan and records the segments shown per digit.
  task automatic collect(input int which, output logic [27:0] segs, output int order_err,
                         output int wrap_seen);
    logic [3:0] a;
    logic [6:0] s;
    int prev;
    int cur;
    prev = -1;
    segs = '1;
    order_err = 0;
    wrap_seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      case (which)
        0:       begin a = an_a; s = seg_a; end
        1:       begin a = an_b; s = seg_b; end
        default: begin a = an_c; s = seg_c; end
      endcase
      cur = idx_of(a);
      if (cur < 0) begin
        order_err++;
      end else begin
        segs[7*cur +: 7] = s;
        if (prev >= 0 && cur != prev) begin
          if (cur != (prev + 1) % 4) order_err++;
          if (prev == 3 && cur == 0) wrap_seen = 1;
        end
        prev = cur;
      end
    end
  endtask

  task automatic test_reset;
    int lit_at;
    rst = 1'b1; done7 = 1'b0; prod7 = '0; done13 = 1'b0; prod13 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy_a, valid_a, bcd_a} !== 18'd0) begin
      bad++; $display("FAIL reset_core: busy/valid/bcd=%h expected 0", {busy_a, valid_a, bcd_a});
    end
    total++;
    if ({an_a, seg_a, dp_a} !== 12'hFFF) begin
      bad++; $display("FAIL reset_display: an=%b seg=%b dp=%b expected 1111/1111111/1", an_a, seg_a, dp_a);
    end
    @(posedge clk); #1 rst = 1'b0;
    lit_at = -1;
    for (int m = 1; m <= 12; m++) begin
      @(posedge clk);
      @(negedge clk);
      if (lit_at < 0 && an_a !== 4'b1111) lit_at = m;
    end
    total++;
    if (lit_at != 5) begin
      bad++; $display("FAIL first_lit: digit lit after %0d cycles expected 5", lit_at);
    end
  endtask

  task automatic test_basic;
    int first_n, pulses, oerr, wrap;
    logic [15:0] val;
    logic [27:0] segs;
    first_n = -1; pulses = 0; val = '0;
    @(posedge clk); #1 done7 = 1'b1; prod7 = 7'd105;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1 if (n == 1) done7 = 1'b0;
      @(negedge clk);
      if (valid_a) begin
        pulses++;
        if (first_n < 0) begin first_n = n; val = bcd_a; end
      end
    end
    total++;
    if (first_n != 9) begin bad++; $display("FAIL basic_latency: valid at %0d expected 9", first_n); end
    total++;
    if (val !== 16'h0105) begin bad++; $display("FAIL basic_value: bcd=%h expected 0105", val); end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL basic_pulses: %0d expected 1", pulses); end
    collect(0, segs, oerr, wrap);
    total++;
    if (segs[6:0] !== 7'b0010010) begin bad++; $display("FAIL basic_d0: seg=%b expected 0010010", segs[6:0]); end
    total++;
    if (segs[13:7] !== 7'b1000000) begin bad++; $display("FAIL basic_d1: seg=%b expected 1000000", segs[13:7]); end
    total++;
    if (segs[20:14] !== 7'b1111001) begin bad++; $display("FAIL basic_d2: seg=%b expected 1111001", segs[20:14]); end
    total++;
    if (segs[27:21] !== 7'b1111111) begin bad++; $display("FAIL basic_d3: seg=%b expected 1111111", segs[27:21]); end
    total++;
    if (oerr != 0) begin bad++; $display("FAIL basic_scan_order: errors=%0d expected 0", oerr); end
  endtask

  task automatic test_level_hold;
    int pulses;
    logic [15:0] val;
    pulses = 0; val = '0;
    @(posedge clk); #1 done7 = 1'b1; prod7 = 7'd127;
    for (int n = 1; n <= 35; n++) begin
      @(posedge clk); #1 if (n == 20) done7 = 1'b0;
      @(negedge clk);
      if (valid_a) begin pulses++; val = bcd_a; end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL hold_pulses: %0d expected 1", pulses); end
    total++;
    if (val !== 16'h0127) begin bad++; $display("FAIL hold_value: bcd=%h expected 0127", val); end
  endtask

  task automatic test_back_to_back;
    int vn[2];
    logic [15:0] vv[2];
    int pulses, drops;
    logic busy_end;
    pulses = 0; drops = 0; busy_end = 1'b1;
    vn[0] = -1; vn[1] = -1; vv[0] = '0; vv[1] = '0;
    @(posedge clk); #1 done7 = 1'b1; prod7 = 7'd12;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 1) done7 = 1'b0;
      if (n == 3) begin done7 = 1'b1; prod7 = 7'd99; end
      if (n == 4) done7 = 1'b0;
      @(negedge clk);
      if (n <= 16 && !busy_a) drops++;
      if (n == 17) busy_end = busy_a;
      if (valid_a) begin
        if (pulses < 2) begin vn[pulses] = n; vv[pulses] = bcd_a; end
        pulses++;
      end
    end
    total++;
    if (pulses != 2) begin bad++; $display("FAIL b2b_pulses: %0d expected 2", pulses); end
    total++;
    if (vv[0] !== 16'h0012 || vn[0] != 9) begin
      bad++; $display("FAIL b2b_first: bcd=%h at %0d expected 0012 at 9", vv[0], vn[0]);
    end
    total++;
    if (vv[1] !== 16'h0099 || vn[1] != 17) begin
      bad++; $display("FAIL b2b_second: bcd=%h at %0d expected 0099 at 17", vv[1], vn[1]);
    end
    total++;
    if (drops != 0 || busy_end !== 1'b0) begin
      bad++; $display("FAIL b2b_busy: gaps=%0d busy_end=%b expected 0 and 0", drops, busy_end);
    end
  endtask

  task automatic test_zero_blank;
    int pulses, oerr_a, oerr_b, wrap;
    logic [27:0] segs_a, segs_b;
    pulses = 0;
    @(posedge clk); #1 done7 = 1'b1; prod7 = 7'd0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1 if (n == 1) done7 = 1'b0;
      @(negedge clk);
      if (valid_a && bcd_a == 16'h0000 && valid_b && bcd_b == 16'h0000) pulses++;
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL zero_pulses: %0d expected 1", pulses); end
    collect(0, segs_a, oerr_a, wrap);
    collect(1, segs_b, oerr_b, wrap);
    total++;
    if (segs_a !== {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}) begin
      bad++; $display("FAIL zero_lzb1: segs=%b expected 1111111_1111111_1111111_1000000", segs_a);
    end
    total++;
    if (segs_b !== {4{7'b1000000}}) begin
      bad++; $display("FAIL zero_lzb0: segs=%b expected 4x1000000", segs_b);
    end
  endtask

  task automatic test_reset_mid;
    int pulses, lit_at;
    logic [22:0] snap;
    pulses = 0; lit_at = -1; snap = '1;
    @(posedge clk); #1 done7 = 1'b1; prod7 = 7'd88;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (n == 1) done7 = 1'b0;
      if (n == 4) rst = 1'b1;
      if (n == 5) rst = 1'b0;
      @(negedge clk);
      if (n == 5) snap = {busy_a, valid_a, bcd_a, an_a, 1'b0};
      if (n > 5 && lit_at < 0 && an_a !== 4'b1111) lit_at = n - 5;
      if (n >= 5 && valid_a) pulses++;
    end
    total++;
    if (snap !== {1'b0, 1'b0, 16'h0000, 4'b1111, 1'b0}) begin
      bad++; $display("FAIL midrst_state: busy/valid/bcd/an=%h expected 00000f", snap[22:1]);
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL midrst_valid: %0d pulses expected 0", pulses); end
    total++;
    if (lit_at != 5) begin bad++; $display("FAIL midrst_relit: %0d expected 5", lit_at); end
  endtask

  task automatic test_wide;
    int first_n, oerr, wrap;
    logic [15:0] val;
    logic [27:0] segs;
    first_n = -1; val = '0;
    @(posedge clk); #1 done13 = 1'b1; prod13 = 13'd8191;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1 if (n == 1) done13 = 1'b0;
      @(negedge clk);
      if (valid_c && first_n < 0) begin first_n = n; val = bcd_c; end
    end
    total++;
    if (first_n != 15 || val !== 16'h8191) begin
      bad++; $display("FAIL wide_value: bcd=%h at %0d expected 8191 at 15", val, first_n);
    end
    collect(2, segs, oerr, wrap);
    total++;
    if (segs !== {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001}) begin
      bad++; $display("FAIL wide_segs: segs=%b expected 0000000_1111001_0010000_1111001", segs);
    end
    total++;
    if (oerr != 0 || wrap != 1) begin
      bad++; $display("FAIL wide_wrap: order_errors=%0d wrap_seen=%0d expected 0 and 1", oerr, wrap);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_level_hold;
    test_back_to_back;
    test_zero_blank;
    test_reset_mid;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
